play_session_ctrl: RTL and testbench

//  Consumer side of the game-state interface: tracks song selection in MENU, and on PLAY

---
 rtl/play_session_if.sv | 37 +++
 rtl/play_session_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_play_session_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/play_session_if.sv
// Game-session bus between the menu/state FSM, chart ROM and LED renderer
// on one side (master) and play_session_ctrl on the other (slave).
//   master drives: state, song_confirm, red/blue/yellow_button, note_data
//   slave drives : note_addr, beat_idx, beat/hit/miss pulses, score, combo,
//                  misses, finish
interface play_session_if #(
    parameter int BEAT_W  = 8,
    parameter int SCORE_W = 10
);
    logic [1:0]         state;
    logic [1:0]         song_confirm;
    logic               red_button;
    logic               blue_button;
    logic               yellow_button;
    logic [2:0]         note_data;
    logic [BEAT_W+1:0]  note_addr;
    logic [BEAT_W-1:0]  beat_idx;
    logic               beat_pulse;
    logic               hit_pulse;
    logic               miss_pulse;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] combo;
    logic [SCORE_W-1:0] misses;
    logic               finish;

    modport master (
        output state, song_confirm, red_button, blue_button, yellow_button, note_data,
        input  note_addr, beat_idx, beat_pulse, hit_pulse, miss_pulse,
               score, combo, misses, finish
    );

    modport slave (
        input  state, song_confirm, red_button, blue_button, yellow_button, note_data,
        output note_addr, beat_idx, beat_pulse, hit_pulse, miss_pulse,
               score, combo, misses, finish
    );
endinterface

// File: rtl/play_session_ctrl.sv
// Play-session controller: remembers the song picked in MENU, and while the
// game is in PLAY walks the song's note chart one beat at a time, judges the
// red/blue/yellow presses against the chart, and keeps score/combo/misses.
// finish is raised once the last beat has closed.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  play_session_if slave modport (game state, song confirm, buttons,
//        chart ROM data in; ROM address, beat index, pulses, counters,
//        finish out)
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for PLAY; song selection accepted; press history clear
// S_RUN  | beat divider running, presses collected and judged each beat
// S_DONE | last beat closed; finish high until game leaves PLAY
module play_session_ctrl #(
    parameter int BEAT_DIV = 25_000_000,
    parameter int BEAT_W   = 8,
    parameter int LEN1     = 64,
    parameter int LEN2     = 96,
    parameter int LEN3     = 128,
    parameter int SCORE_W  = 10
) (
    input  logic          clk,
    input  logic          rst,
    play_session_if.slave bus
);
    localparam int                 DIV_W    = $clog2(BEAT_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BEAT_DIV - 1);
    localparam logic [SCORE_W-1:0] SAT      = '1;
    localparam logic [1:0]         ST_MENU  = 2'd1;
    localparam logic [1:0]         ST_PLAY  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [1:0]         sel_song_q, sel_song_d;
    logic [1:0]         song_id_q, song_id_d;
    logic [BEAT_W-1:0]  last_idx_q, last_idx_d;
    logic [BEAT_W-1:0]  beat_idx_q, beat_idx_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] combo_q, combo_d;
    logic [SCORE_W-1:0] misses_q, misses_d;
    logic [2:0]         mask_q, mask_d;
    logic [2:0]         prev_q, prev_d;
    logic [2:0]         note_q, note_d;

    logic [2:0] btn;
    logic [2:0] rise;
    logic [2:0] eff_mask;
    logic       beat_close;
    logic       judge_hit;
    logic       judge_miss;

    // Storing len-1 keeps the end-of-song compare in BEAT_W bits even when a
    // song is the full 2^BEAT_W beats long.
    function automatic logic [BEAT_W-1:0] last_of(input logic [1:0] id);
        case (id)
            2'd2:    last_of = BEAT_W'(LEN2 - 1);
            2'd3:    last_of = BEAT_W'(LEN3 - 1);
            default: last_of = BEAT_W'(LEN1 - 1);
        endcase
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        sat_inc = (v == SAT) ? v : v + SCORE_W'(1);
    endfunction

    always_comb begin
        fsm_d      = fsm_q;
        sel_song_d = sel_song_q;
        song_id_d  = song_id_q;
        last_idx_d = last_idx_q;
        beat_idx_d = beat_idx_q;
        div_d      = div_q;
        score_d    = score_q;
        combo_d    = combo_q;
        misses_d   = misses_q;
        mask_d     = mask_q;
        prev_d     = prev_q;
        // The ROM word is re-registered every cycle; by the beat close it has
        // long since settled on the current beat's address.
        note_d     = bus.note_data;
        btn        = {bus.yellow_button, bus.blue_button, bus.red_button};
        rise       = btn & ~prev_q;
        // A press landing on the close cycle itself still belongs to this beat.
        eff_mask   = mask_q | rise;
        beat_close = 1'b0;
        judge_hit  = 1'b0;
        judge_miss = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                prev_d = '0;
                mask_d = '0;
                if (bus.state == ST_MENU && bus.song_confirm != 2'd0) begin
                    sel_song_d = bus.song_confirm;
                end
                if (bus.state == ST_PLAY) begin
                    fsm_d      = S_RUN;
                    song_id_d  = sel_song_q;
                    last_idx_d = last_of(sel_song_q);
                    beat_idx_d = '0;
                    div_d      = '0;
                    score_d    = '0;
                    combo_d    = '0;
                    misses_d   = '0;
                end
            end
            S_RUN: begin
                if (bus.state != ST_PLAY) begin
                    // Abort: counters are left as they were for the renderer.
                    fsm_d = S_IDLE;
                end else begin
                    prev_d = btn;
                    if (div_q == DIV_LAST) begin
                        beat_close = 1'b1;
                        div_d      = '0;
                        mask_d     = '0;
                        if (note_q != 3'b000) begin
                            if (eff_mask == note_q) begin
                                judge_hit = 1'b1;
                                score_d   = sat_inc(score_q);
                                combo_d   = sat_inc(combo_q);
                            end else begin
                                judge_miss = 1'b1;
                                misses_d   = sat_inc(misses_q);
                                combo_d    = '0;
                            end
                        end
                        if (beat_idx_q == last_idx_q) begin
                            fsm_d = S_DONE;
                        end else begin
                            beat_idx_d = beat_idx_q + BEAT_W'(1);
                        end
                    end else begin
                        div_d  = div_q + DIV_W'(1);
                        mask_d = eff_mask;
                    end
                end
            end
            S_DONE: begin
                if (bus.state != ST_PLAY) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            sel_song_q <= 2'd1;
            song_id_q  <= 2'd0;
            last_idx_q <= '0;
            beat_idx_q <= '0;
            div_q      <= '0;
            score_q    <= '0;
            combo_q    <= '0;
            misses_q   <= '0;
            mask_q     <= '0;
            prev_q     <= '0;
            note_q     <= '0;
        end else begin
            fsm_q      <= fsm_d;
            sel_song_q <= sel_song_d;
            song_id_q  <= song_id_d;
            last_idx_q <= last_idx_d;
            beat_idx_q <= beat_idx_d;
            div_q      <= div_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            misses_q   <= misses_d;
            mask_q     <= mask_d;
            prev_q     <= prev_d;
            note_q     <= note_d;
        end
    end

    assign bus.note_addr  = {song_id_q, beat_idx_q};
    assign bus.beat_idx   = beat_idx_q;
    assign bus.beat_pulse = beat_close;
    assign bus.hit_pulse  = judge_hit;
    assign bus.miss_pulse = judge_miss;
    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.misses     = misses_q;
    assign bus.finish     = (fsm_q == S_DONE);
endmodule

// File: tb/tb_play_session_ctrl.sv
// Bench for play_session_ctrl with BEAT_DIV=4, LEN1=3, LEN2=2, LEN3=20,
// SCORE_W=4. A behavioural chart ROM answers one clock after note_addr.
module tb_play_session_ctrl;
    localparam int         MAXS     = 15;
    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_MENU  = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    typedef struct {
        logic [2:0] c0, c1, c2;
        logic [2:0] t0, t1, t2;
        int         sc, co, mi;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    play_session_if #(.BEAT_W(8), .SCORE_W(4)) bus ();

    play_session_ctrl #(
        .BEAT_DIV(4), .BEAT_W(8), .LEN1(3), .LEN2(2), .LEN3(20), .SCORE_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [2:0] chart [0:1023];
    always @(posedge clk) bus.note_data <= chart[bus.note_addr];

    int checks = 0;
    int errors = 0;

    int         m_song, m_len, m_beat, m_score, m_combo, m_miss, m_sel;
    logic [2:0] m_prev;

    vec_t tbl [6];

    function automatic int song_len(input int s);
        case (s)
            2:       return 2;
            3:       return 20;
            default: return 3;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > MAXS) ? MAXS : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] st, input logic [1:0] sc, input logic [2:0] lv);
        @(posedge clk);
        #1;
        bus.state         = st;
        bus.song_confirm  = sc;
        bus.red_button    = lv[0];
        bus.blue_button   = lv[1];
        bus.yellow_button = lv[2];
        #1;
    endtask

    task automatic chk_zero();
        chk("rst_note_addr", 32'(bus.note_addr), 0);
        chk("rst_beat_idx", 32'(bus.beat_idx), 0);
        chk("rst_beat_pulse", 32'(bus.beat_pulse), 0);
        chk("rst_hit", 32'(bus.hit_pulse), 0);
        chk("rst_miss", 32'(bus.miss_pulse), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_combo", 32'(bus.combo), 0);
        chk("rst_misses", 32'(bus.misses), 0);
        chk("rst_finish", 32'(bus.finish), 0);
    endtask

    task automatic model_start(input int s);
        m_song  = s;
        m_len   = song_len(s);
        m_beat  = 0;
        m_score = 0;
        m_combo = 0;
        m_miss  = 0;
        m_prev  = 3'b000;
    endtask

    task automatic start_session(input int s);
        drive(ST_MENU, 2'(s), 3'b000);
        drive(ST_MENU, 2'd0, 3'b000);
        drive(ST_PLAY, 2'd0, 3'b000);
        m_sel = s;
        model_start(s);
    endtask

    // One beat: lv holds the button levels for the 4 cycles, cycle c in lv[3c+:3].
    // A lane counts as pressed in a beat if it is up in some cycle of the
    // beat and was down in the cycle before.
    task automatic run_beat(input logic [11:0] lv);
        logic [2:0] note, pressed, p, cur;
        logic       eh, em;
        note    = chart[{2'(m_song), 8'(m_beat)}];
        pressed = 3'b000;
        p       = m_prev;
        for (int c = 0; c < 4; c++) begin
            cur     = lv[c*3 +: 3];
            pressed = pressed | (cur & ~p);
            p       = cur;
        end
        eh = (note != 3'b000) && (pressed == note);
        em = (note != 3'b000) && (pressed != note);
        for (int c = 0; c < 4; c++) begin
            drive(ST_PLAY, 2'd0, lv[c*3 +: 3]);
            if (c == 0) begin
                chk("beat_idx", 32'(bus.beat_idx), 32'(m_beat));
                chk("note_addr", 32'(bus.note_addr), 32'({2'(m_song), 8'(m_beat)}));
                chk("score", 32'(bus.score), 32'(m_score));
                chk("combo", 32'(bus.combo), 32'(m_combo));
                chk("misses", 32'(bus.misses), 32'(m_miss));
            end
            chk("finish_run", 32'(bus.finish), 0);
            chk("beat_pulse", 32'(bus.beat_pulse), 32'(c == 3));
            chk("hit_pulse", 32'(bus.hit_pulse), 32'((c == 3) && eh));
            chk("miss_pulse", 32'(bus.miss_pulse), 32'((c == 3) && em));
        end
        m_prev = p;
        if (eh) begin
            m_score = sat(m_score + 1);
            m_combo = sat(m_combo + 1);
        end
        if (em) begin
            m_miss  = sat(m_miss + 1);
            m_combo = 0;
        end
        if (m_beat < m_len - 1) m_beat++;
    endtask

    task automatic finish_check();
        drive(ST_PLAY, 2'd0, 3'b111);
        chk("finish_done", 32'(bus.finish), 1);
        chk("done_beat_pulse", 32'(bus.beat_pulse), 0);
        chk("done_hit", 32'(bus.hit_pulse), 0);
        chk("done_miss", 32'(bus.miss_pulse), 0);
        chk("done_beat_idx", 32'(bus.beat_idx), 32'(m_len - 1));
        chk("done_score", 32'(bus.score), 32'(m_score));
        chk("done_combo", 32'(bus.combo), 32'(m_combo));
        chk("done_misses", 32'(bus.misses), 32'(m_miss));
        drive(ST_FIN, 2'd0, 3'b000);
        chk("finish_hold", 32'(bus.finish), 1);
        drive(ST_MENU, 2'd0, 3'b000);
        chk("finish_clear", 32'(bus.finish), 0);
    endtask

    task automatic tap_session(input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2);
        run_beat({3'b000, t0, t0, 3'b000});
        run_beat({3'b000, t1, t1, 3'b000});
        run_beat({3'b000, t2, t2, 3'b000});
        finish_check();
    endtask

    task automatic set_song1(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        chart[{2'd1, 8'd0}] = a;
        chart[{2'd1, 8'd1}] = b;
        chart[{2'd1, 8'd2}] = c;
    endtask

    initial begin
        logic [11:0] lv;
        logic [2:0]  note, tgt, cur;
        int          sg, ln;

        tbl[0] = '{3'b001, 3'b110, 3'b000, 3'b001, 3'b110, 3'b000, 2, 2, 0};
        tbl[1] = '{3'b001, 3'b110, 3'b000, 3'b010, 3'b110, 3'b101, 1, 1, 1};
        tbl[2] = '{3'b111, 3'b100, 3'b010, 3'b111, 3'b100, 3'b000, 2, 0, 1};
        tbl[3] = '{3'b011, 3'b011, 3'b011, 3'b000, 3'b011, 3'b001, 1, 0, 2};
        tbl[4] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 0, 0, 0};
        tbl[5] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3, 3, 0};

        for (int i = 0; i < 1024; i++) chart[i] = 3'b000;
        rst               = 1'b1;
        bus.state         = ST_START;
        bus.song_confirm  = 2'd0;
        bus.red_button    = 1'b0;
        bus.blue_button   = 1'b0;
        bus.yellow_button = 1'b0;
        m_sel             = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero();
        rst = 1'b0;

        // Table-driven song-1 sessions with single taps per beat.
        for (int i = 0; i < 6; i++) begin
            set_song1(tbl[i].c0, tbl[i].c1, tbl[i].c2);
            start_session(1);
            tap_session(tbl[i].t0, tbl[i].t1, tbl[i].t2);
            chk("tbl_score", 32'(bus.score), 32'(tbl[i].sc));
            chk("tbl_combo", 32'(bus.combo), 32'(tbl[i].co));
            chk("tbl_misses", 32'(bus.misses), 32'(tbl[i].mi));
        end

        // Red held across two beats counts once.
        set_song1(3'b001, 3'b001, 3'b000);
        start_session(1);
        run_beat(12'b001_001_001_001);
        run_beat(12'b001_001_001_001);
        run_beat(12'b000_000_000_000);
        finish_check();
        chk("hold_score", 32'(bus.score), 1);
        chk("hold_combo", 32'(bus.combo), 0);
        chk("hold_misses", 32'(bus.misses), 1);

        // Press arriving on the close cycle belongs to the closing beat.
        set_song1(3'b010, 3'b000, 3'b000);
        start_session(1);
        run_beat({3'b010, 9'b0});
        run_beat(12'b0);
        run_beat(12'b0);
        finish_check();
        chk("late_score", 32'(bus.score), 1);

        // Song 2: two beats, finish after 8 clocks.
        chart[{2'd2, 8'd0}] = 3'b001;
        chart[{2'd2, 8'd1}] = 3'b010;
        start_session(2);
        run_beat({3'b000, 3'b001, 3'b001, 3'b000});
        run_beat({3'b000, 3'b010, 3'b010, 3'b000});
        finish_check();
        chk("song2_score", 32'(bus.score), 2);

        // Confirm outside MENU is ignored: START -> PLAY reuses song 2.
        drive(ST_START, 2'd3, 3'b000);
        drive(ST_PLAY, 2'd0, 3'b000);
        model_start(m_sel);
        run_beat(12'b0);
        run_beat(12'b0);
        finish_check();
        chk("ignored_confirm_misses", 32'(bus.misses), 2);

        // Abort mid-RUN: back to IDLE, finish stays low, counters hold.
        set_song1(3'b001, 3'b010, 3'b100);
        start_session(1);
        run_beat({3'b000, 3'b001, 3'b001, 3'b000});
        drive(ST_PLAY, 2'd0, 3'b000);
        chk("abort_beat_idx", 32'(bus.beat_idx), 1);
        drive(ST_MENU, 2'd0, 3'b000);
        for (int k = 0; k < 8; k++) begin
            drive(ST_MENU, 2'd0, 3'b111);
            chk("abort_beat_pulse", 32'(bus.beat_pulse), 0);
            chk("abort_hit", 32'(bus.hit_pulse), 0);
            chk("abort_finish", 32'(bus.finish), 0);
            chk("abort_score", 32'(bus.score), 1);
        end

        // Reset mid-RUN at beat 1; restart after release uses song 1.
        chart[{2'd3, 8'd0}] = 3'b001;
        start_session(3);
        run_beat({3'b000, 3'b001, 3'b001, 3'b000});
        drive(ST_PLAY, 2'd0, 3'b000);
        chk("pre_rst_beat_idx", 32'(bus.beat_idx), 1);
        rst = 1'b1;
        #1;
        chk_zero();
        drive(ST_PLAY, 2'd0, 3'b000);
        chk_zero();
        rst = 1'b0;
        m_sel = 1;
        model_start(1);
        tap_session(3'b001, 3'b010, 3'b100);
        chk("post_rst_score", 32'(bus.score), 3);

        // 20 consecutive hits on song 3 saturate score and combo.
        for (int b = 0; b < 20; b++) chart[{2'd3, 8'(b)}] = 3'b001;
        start_session(3);
        for (int b = 0; b < 20; b++) run_beat({3'b000, 3'b001, 3'b001, 3'b000});
        finish_check();
        chk("sat_score", 32'(bus.score), 15);
        chk("sat_combo", 32'(bus.combo), 15);
        chk("sat_misses", 32'(bus.misses), 0);

        // Randomised sessions against the beat-level model.
        for (int s = 0; s < 12; s++) begin
            sg = $urandom_range(1, 3);
            ln = song_len(sg);
            for (int b = 0; b < ln; b++) begin
                chart[{2'(sg), 8'(b)}] = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            end
            start_session(sg);
            for (int b = 0; b < ln; b++) begin
                note = chart[{2'(sg), 8'(b)}];
                tgt  = ($urandom_range(0, 1) == 1) ? note : 3'($urandom_range(0, 7));
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(0, 3) == 0) cur = 3'($urandom_range(0, 7));
                    else if (c == 1 || c == 2) cur = tgt;
                    else cur = 3'b000;
                    lv[c*3 +: 3] = cur;
                end
                run_beat(lv);
            end
            finish_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
